cpu_bus_arbiter: RTL and testbench
==================================

Name: cpu_bus_arbiter

Overview:
- Sits directly downstream of the CPU core. It merges the core's instruction bus (read-only) and data bus (read/write) onto the single system memory bus.
- Grants are fixed-priority with data bus first. A starvation guard prevents the instruction bus from being locked out.
- A watchdog aborts hung slave transactions.
- Request/ready handshake on every port is the core's: request held stable until ready pulses.

Parameters:
- STARVE_LIMIT, 4: consecutive dbus grants allowed while ibus waits; the next grant is forced to ibus. Must be at least 1.
- TIMEOUT, 1024: slave cycles allowed per transaction before abort. 0 disables the watchdog.
- TW, 11: timeout counter width. Must hold TIMEOUT.

Ports:
- i_clock, in, 1: single clock, all logic rising-edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_ibus_request, in, 1: fetch request, held until o_ibus_ready.
- o_ibus_ready, out, 1: one-cycle completion pulse to fetch.
- i_ibus_address, in, 32: fetch address.
- o_ibus_rdata, out, 32: fetch read data, valid with o_ibus_ready.
- i_dbus_rw, in, 1: 1 = write, 0 = read.
- i_dbus_request, in, 1: data request, held until o_dbus_ready.
- o_dbus_ready, out, 1: one-cycle completion pulse to memory stage.
- i_dbus_address, in, 32: data address.
- i_dbus_wdata, in, 32: write data.
- o_dbus_rdata, out, 32: read data, valid with o_dbus_ready.
- o_bus_rw, out, 1: system bus direction.
- o_bus_request, out, 1: system bus request.
- i_bus_ready, in, 1: system bus completion pulse.
- o_bus_address, out, 32: system bus address.
- i_bus_rdata, in, 32: system bus read data.
- o_bus_wdata, out, 32: system bus write data.
- o_timeout, out, 1: sticky watchdog flag, cleared only by reset.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP.
- Reset (async, i_reset low): state IDLE.
  - All outputs 0, including o_timeout.
  - Starvation counter and timeout counter 0.
  - Reset mid-transaction aborts it silently: no ready pulse is issued and o_bus_request drops immediately.
- IDLE, arbitration:
  - dbus wins if requested, unless ibus is also requested and starve_cnt == STARVE_LIMIT; then ibus wins.
  - Only ibus requested: ibus wins.
  - Neither requested: stay in IDLE.
- Grant latches the winner's address/rw/wdata into o_bus_* and sets o_bus_request = 1 on the next edge.
  - An ibus grant forces o_bus_rw = 0 and o_bus_wdata = 0.
  - Master inputs are ignored after the latch.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a dbus grant while ibus is requesting.
  - Clears on any ibus grant.
  - Clears on a dbus grant with ibus idle.
- BUSY_x, completing: on i_bus_ready = 1, capture i_bus_rdata into the granted master's rdata register, clear o_bus_request and go to RESP.
  - The granted master's ready is 1 during RESP only.
  - The other master's rdata register holds its previous value.
- BUSY_x, watchdog: the timeout counter counts cycles in BUSY_x.
  - If TIMEOUT != 0 and the count reaches TIMEOUT without i_bus_ready, set o_timeout and clear o_bus_request.
  - Load rdata = 32'hFFFF_FFFF, then go to RESP, so the master still gets exactly one ready pulse.
- RESP: lasts exactly one cycle, then IDLE unconditionally. The timeout counter clears.
- Back-to-back: a request still high in the IDLE cycle after RESP is a new transaction.
- Latency: master request in cycle c → o_bus_request in c+1.
  - With a zero-wait slave (ready in c+1), master ready is in c+2.
  - Minimum issue interval per master: 3 cycles.
- i_bus_ready outside BUSY_x is ignored.
- Simultaneous i_bus_ready and timeout expiry in the same cycle: ready wins and o_timeout stays unchanged.
- Never more than one o_*_ready high in any cycle. o_bus_request is never high in IDLE or RESP.

Test Plan:
- Lone ibus read of 0x0000_0100, slave returns 0xDEAD_BEEF zero-wait → o_bus_request at c+1 with rw=0; o_ibus_ready=1 and o_ibus_rdata=0xDEAD_BEEF at c+2 only; o_dbus_ready stays 0.
- dbus write of 0x1234_5678 to 0x2000_0000 raised in the same cycle as an ibus request → dbus granted first (o_bus_rw=1, o_bus_wdata=0x1234_5678); ibus granted in the IDLE cycle after the dbus RESP.
- Continuous dbus requests with ibus held high, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Slave never asserts ready, TIMEOUT=8 → o_bus_request drops after 8 BUSY cycles; o_dbus_ready pulses once with rdata 0xFFFF_FFFF; o_timeout=1 and remains 1 through later good transactions.
- Slave ready on exactly the TIMEOUT cycle → normal data delivered and o_timeout stays 0.
- i_reset driven low asynchronously mid-BUSY_D with slave stalled → o_bus_request and all outputs 0 immediately; after release, a fresh ibus request completes normally with no stale ready pulse.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data buses onto one system memory bus.
// Fixed priority (data first) with a starvation guard for fetch, plus a transaction watchdog.
module cpu_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1024,
    parameter int TW           = 11
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic        o_timeout,
    output logic [1:0]  o_state
);

    // Every port follows the core's handshake: a request is held stable until its
    // ready pulses for exactly one cycle; the slave's ready is likewise a one-cycle pulse.

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RESP = 2'd3} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam bit            WD_EN      = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         state;
    logic [SW-1:0]  starve_cnt;
    logic [TW-1:0]  tcnt;

    logic           pick_i;
    logic           expired;
    logic           done;
    logic [31:0]    resp_data;
    logic [SW-1:0]  starve_inc;

    assign o_state = state;

    always_comb begin
        pick_i     = i_ibus_request && (!i_dbus_request || (starve_cnt == STARVE_MAX));
        // tcnt holds the number of BUSY cycles already elapsed, so the last allowed
        // cycle is the one where it equals TIMEOUT-1.
        expired    = WD_EN && (tcnt == T_LAST);
        done       = i_bus_ready || expired;
        resp_data  = i_bus_ready ? i_bus_rdata : 32'hFFFF_FFFF;
        starve_inc = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            tcnt          <= '0;
            o_ibus_ready  <= 1'b0;
            o_ibus_rdata  <= '0;
            o_dbus_ready  <= 1'b0;
            o_dbus_rdata  <= '0;
            o_bus_rw      <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_ibus_ready <= 1'b0;
                    o_dbus_ready <= 1'b0;
                    tcnt         <= '0;
                    if (pick_i) begin
                        o_bus_address <= i_ibus_address;
                        o_bus_rw      <= 1'b0;
                        o_bus_wdata   <= '0;
                        o_bus_request <= 1'b1;
                        starve_cnt    <= '0;
                        state         <= BUSY_I;
                    end else if (i_dbus_request) begin
                        o_bus_address <= i_dbus_address;
                        o_bus_rw      <= i_dbus_rw;
                        o_bus_wdata   <= i_dbus_wdata;
                        o_bus_request <= 1'b1;
                        starve_cnt    <= i_ibus_request ? starve_inc : '0;
                        state         <= BUSY_D;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        if (state == BUSY_I) begin
                            o_ibus_rdata <= resp_data;
                            o_ibus_ready <= 1'b1;
                        end else begin
                            o_dbus_rdata <= resp_data;
                            o_dbus_ready <= 1'b1;
                        end
                        // A real completion in the expiry cycle takes precedence.
                        if (!i_bus_ready) o_timeout <= 1'b1;
                        o_bus_request <= 1'b0;
                        tcnt          <= '0;
                        state         <= RESP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP: begin
                    o_ibus_ready <= 1'b0;
                    o_dbus_ready <= 1'b0;
                    tcnt         <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: arbitration order, starvation guard, watchdog and async reset.
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_request = 1'b0;
    logic        ibus_ready;
    logic [31:0] ibus_address = '0;
    logic [31:0] ibus_rdata;
    logic        dbus_rw = 1'b0;
    logic        dbus_request = 1'b0;
    logic        dbus_ready;
    logic [31:0] dbus_address = '0;
    logic [31:0] dbus_wdata = '0;
    logic [31:0] dbus_rdata;
    logic        bus_rw;
    logic        bus_request;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_address;
    logic [31:0] bus_rdata = '0;
    logic [31:0] bus_wdata;
    logic        timeout;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8), .TW(11)) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_ibus_request (ibus_request),
        .o_ibus_ready   (ibus_ready),
        .i_ibus_address (ibus_address),
        .o_ibus_rdata   (ibus_rdata),
        .i_dbus_rw      (dbus_rw),
        .i_dbus_request (dbus_request),
        .o_dbus_ready   (dbus_ready),
        .i_dbus_address (dbus_address),
        .i_dbus_wdata   (dbus_wdata),
        .o_dbus_rdata   (dbus_rdata),
        .o_bus_rw       (bus_rw),
        .o_bus_request  (bus_request),
        .i_bus_ready    (bus_ready),
        .o_bus_address  (bus_address),
        .i_bus_rdata    (bus_rdata),
        .o_bus_wdata    (bus_wdata),
        .o_timeout      (timeout),
        .o_state        (state)
    );

    // clock/reset block
    initial forever #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (bus_request !== 1'b0) begin n_bad++; $display("FAIL reset_bus_request: got %b want 0", bus_request); end
        n_cmp++; if ({ibus_ready, dbus_ready, timeout, bus_rw} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {ibus_ready, dbus_ready, timeout, bus_rw}); end
        n_cmp++; if ({bus_address, bus_wdata, ibus_rdata, dbus_rdata} !== 128'b0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus_address, bus_wdata, ibus_rdata, dbus_rdata}); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus_request !== 1'b0) begin n_bad++; $display("FAIL idle_no_request: got %b want 0", bus_request); end
    endtask

    task automatic test_ibus_read;
        ibus_request = 1'b1; ibus_address = 32'h0000_0100;
        tick();
        n_cmp++; if ({bus_request, bus_rw} !== 2'b10) begin n_bad++; $display("FAIL ird_grant: got req/rw %b want 10", {bus_request, bus_rw}); end
        n_cmp++; if (bus_address !== 32'h0000_0100) begin n_bad++; $display("FAIL ird_addr: got %h want 00000100", bus_address); end
        n_cmp++; if (ibus_ready !== 1'b0) begin n_bad++; $display("FAIL ird_early_ready: got %b want 0", ibus_ready); end
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready, bus_request} !== 3'b100) begin n_bad++; $display("FAIL ird_resp: got i/d/req %b want 100", {ibus_ready, dbus_ready, bus_request}); end
        n_cmp++; if (ibus_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ird_rdata: got %h want deadbeef", ibus_rdata); end
        ibus_request = 1'b0; bus_ready = 1'b0;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready, bus_request} !== 3'b000) begin n_bad++; $display("FAIL ird_single_pulse: got %b want 000", {ibus_ready, dbus_ready, bus_request}); end
    endtask

    task automatic test_priority;
        ibus_request = 1'b1; ibus_address = 32'h0000_0300;
        dbus_request = 1'b1; dbus_rw = 1'b1; dbus_address = 32'h2000_0000; dbus_wdata = 32'h1234_5678;
        tick();
        n_cmp++; if ({bus_request, bus_rw} !== 2'b11) begin n_bad++; $display("FAIL pri_dgrant: got req/rw %b want 11", {bus_request, bus_rw}); end
        n_cmp++; if ({bus_address, bus_wdata} !== {32'h2000_0000, 32'h1234_5678}) begin n_bad++; $display("FAIL pri_daddr: got %h want 2000000012345678", {bus_address, bus_wdata}); end
        bus_ready = 1'b1; bus_rdata = 32'h0000_0055;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready} !== 2'b01) begin n_bad++; $display("FAIL pri_dresp: got i/d %b want 01", {ibus_ready, dbus_ready}); end
        dbus_request = 1'b0; bus_ready = 1'b0;
        tick();
        n_cmp++; if (bus_request !== 1'b0) begin n_bad++; $display("FAIL pri_idle: got %b want 0", bus_request); end
        tick();
        n_cmp++; if ({bus_request, bus_rw} !== 2'b10) begin n_bad++; $display("FAIL pri_igrant: got req/rw %b want 10", {bus_request, bus_rw}); end
        n_cmp++; if ({bus_address, bus_wdata} !== {32'h0000_0300, 32'h0}) begin n_bad++; $display("FAIL pri_iaddr: got %h want 0000030000000000", {bus_address, bus_wdata}); end
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready} !== 2'b10) begin n_bad++; $display("FAIL pri_iresp: got i/d %b want 10", {ibus_ready, dbus_ready}); end
        n_cmp++; if ({ibus_rdata, dbus_rdata} !== {32'hCAFE_0001, 32'h0000_0055}) begin n_bad++; $display("FAIL pri_rdata_hold: got %h want cafe000100000055", {ibus_rdata, dbus_rdata}); end
        ibus_request = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        logic [9:0] is_i;
        is_i = 10'b10_0001_0000;  // bit k set: grant k goes to ibus (D,D,D,D,I,D,D,D,D,I)
        ibus_request = 1'b1; ibus_address = 32'h0000_1000;
        dbus_request = 1'b1; dbus_rw = 1'b1; dbus_address = 32'hD000_0000; dbus_wdata = 32'h0000_AAAA;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (bus_address !== (is_i[k] ? 32'h0000_1000 : 32'hD000_0000)) begin
                n_bad++; $display("FAIL starve_grant%0d: got %h want %h", k, bus_address, is_i[k] ? 32'h0000_1000 : 32'hD000_0000);
            end
            bus_ready = 1'b1; bus_rdata = 32'(k);
            tick();
            n_cmp++;
            if ({ibus_ready, dbus_ready} !== (is_i[k] ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL starve_ready%0d: got i/d %b want %b", k, {ibus_ready, dbus_ready}, is_i[k] ? 2'b10 : 2'b01);
            end
            bus_ready = 1'b0;
            tick();
        end
        ibus_request = 1'b0; dbus_request = 1'b0;
        tick();
    endtask

    task automatic test_stray_ready;
        bus_ready = 1'b1; bus_rdata = 32'h5555_5555;
        repeat (3) tick();
        n_cmp++; if ({ibus_ready, dbus_ready, bus_request} !== 3'b000) begin n_bad++; $display("FAIL stray_ready: got %b want 000", {ibus_ready, dbus_ready, bus_request}); end
        bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout_edge;
        dbus_request = 1'b1; dbus_rw = 1'b0; dbus_address = 32'h0000_5000;
        tick();
        repeat (7) tick();
        n_cmp++; if (bus_request !== 1'b1) begin n_bad++; $display("FAIL tedge_busy8: got %b want 1", bus_request); end
        bus_ready = 1'b1; bus_rdata = 32'h600D_F00D;
        tick();
        n_cmp++; if ({dbus_ready, timeout} !== 2'b10) begin n_bad++; $display("FAIL tedge_resp: got rdy/to %b want 10", {dbus_ready, timeout}); end
        n_cmp++; if (dbus_rdata !== 32'h600D_F00D) begin n_bad++; $display("FAIL tedge_rdata: got %h want 600df00d", dbus_rdata); end
        dbus_request = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int n;
        dbus_request = 1'b1; dbus_rw = 1'b0; dbus_address = 32'h0000_6000;
        tick();
        n = 0;
        while (bus_request === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 8", n); end
        n_cmp++; if ({ibus_ready, dbus_ready, timeout} !== 3'b011) begin n_bad++; $display("FAIL to_resp: got i/d/to %b want 011", {ibus_ready, dbus_ready, timeout}); end
        n_cmp++; if (dbus_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_rdata: got %h want ffffffff", dbus_rdata); end
        dbus_request = 1'b0;
        tick();
        n_cmp++; if ({dbus_ready, timeout} !== 2'b01) begin n_bad++; $display("FAIL to_after: got rdy/to %b want 01", {dbus_ready, timeout}); end
        ibus_request = 1'b1; ibus_address = 32'h0000_0040;
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        n_cmp++; if ({ibus_ready, timeout} !== 2'b11) begin n_bad++; $display("FAIL to_sticky: got rdy/to %b want 11", {ibus_ready, timeout}); end
        n_cmp++; if (ibus_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL to_good_rdata: got %h want 11111111", ibus_rdata); end
        ibus_request = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        dbus_request = 1'b1; dbus_rw = 1'b1; dbus_address = 32'h0000_7000; dbus_wdata = 32'h0000_0077;
        tick();
        n_cmp++; if (bus_request !== 1'b1) begin n_bad++; $display("FAIL ar_busy: got %b want 1", bus_request); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus_request, ibus_ready, dbus_ready, timeout, bus_rw} !== 5'b0) begin n_bad++; $display("FAIL ar_flags: got %b want 00000", {bus_request, ibus_ready, dbus_ready, timeout, bus_rw}); end
        n_cmp++; if ({bus_address, bus_wdata, ibus_rdata, dbus_rdata} !== 128'b0) begin n_bad++; $display("FAIL ar_data: got %h want 0", {bus_address, bus_wdata, ibus_rdata, dbus_rdata}); end
        dbus_request = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready, bus_request} !== 3'b000) begin n_bad++; $display("FAIL ar_no_stale: got %b want 000", {ibus_ready, dbus_ready, bus_request}); end
        ibus_request = 1'b1; ibus_address = 32'h0000_0800;
        tick();
        n_cmp++; if ({bus_request, bus_rw, bus_address} !== {2'b10, 32'h0000_0800}) begin n_bad++; $display("FAIL ar_igrant: got %h want 200000800", {bus_request, bus_rw, bus_address}); end
        bus_ready = 1'b1; bus_rdata = 32'h8888_8888;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready} !== 2'b10) begin n_bad++; $display("FAIL ar_iresp: got i/d %b want 10", {ibus_ready, dbus_ready}); end
        n_cmp++; if (ibus_rdata !== 32'h8888_8888) begin n_bad++; $display("FAIL ar_rdata: got %h want 88888888", ibus_rdata); end
        ibus_request = 1'b0; bus_ready = 1'b0;
        tick();
        n_cmp++; if ({ibus_ready, dbus_ready, bus_request} !== 3'b000) begin n_bad++; $display("FAIL ar_done: got %b want 000", {ibus_ready, dbus_ready, bus_request}); end
    endtask

    initial begin
        test_reset();
        test_ibus_read();
        test_priority();
        test_starvation();
        test_stray_ready();
        test_timeout_edge();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
